// File: rtl/cdb_arbiter_if.sv
// ---------------------------------------------------------------------------
// cdb_arbiter_if
// Bundles the two result-source handshakes (ADD, MUL) and the registered
// common data bus broadcast into one interface.
//   ADD source : valid_Result_add, Pw_Result_add, tag_ROB_add -> ready_add
//   MUL source : valid_Result_mul, Pw_Result_mul, tag_ROB_mul -> ready_mul
//   CDB        : valid_cdb, Pw_cdb, tag_ROB_cdb, src_cdb, cnt_conflict
// Modports:
//   master - the execution-unit side that offers results and watches the CDB
//   slave  - the arbiter itself
// ---------------------------------------------------------------------------
interface cdb_arbiter_if #(
    parameter int PREG_W = 5,
    parameter int TAG_W  = 4,
    parameter int CNT_W  = 16
);
    logic              valid_Result_add;
    logic [PREG_W-1:0] Pw_Result_add;
    logic [TAG_W-1:0]  tag_ROB_add;
    logic              ready_add;

    logic              valid_Result_mul;
    logic [PREG_W-1:0] Pw_Result_mul;
    logic [TAG_W-1:0]  tag_ROB_mul;
    logic              ready_mul;

    logic              valid_cdb;
    logic [PREG_W-1:0] Pw_cdb;
    logic [TAG_W-1:0]  tag_ROB_cdb;
    logic              src_cdb;
    logic [CNT_W-1:0]  cnt_conflict;

    modport master (
        output valid_Result_add, Pw_Result_add, tag_ROB_add,
        output valid_Result_mul, Pw_Result_mul, tag_ROB_mul,
        input  ready_add, ready_mul,
        input  valid_cdb, Pw_cdb, tag_ROB_cdb, src_cdb, cnt_conflict
    );

    modport slave (
        input  valid_Result_add, Pw_Result_add, tag_ROB_add,
        input  valid_Result_mul, Pw_Result_mul, tag_ROB_mul,
        output ready_add, ready_mul,
        output valid_cdb, Pw_cdb, tag_ROB_cdb, src_cdb, cnt_conflict
    );
endinterface

// File: rtl/cdb_arbiter.sv
// ---------------------------------------------------------------------------
// cdb_arbiter
// Shares one registered common data bus between the ADD and MUL result paths.
// Each source feeds a private DEPTH-entry FIFO with valid/ready backpressure;
// a round-robin arbiter drains one head per cycle into the CDB register.
// Ports:
//   clk   - clock, all state updates on the rising edge
//   rst   - synchronous reset, active-low (has priority over flush)
//   flush - synchronous pipeline flush, discards every queued result
//   bus   - cdb_arbiter_if.slave: both source handshakes plus CDB outputs
// ---------------------------------------------------------------------------
module cdb_arbiter #(
    parameter int PREG_W = 5,
    parameter int TAG_W  = 4,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    cdb_arbiter_if.slave  bus
);

    // A single-entry queue still needs a 1-bit pointer to keep the vectors legal.
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNTQ_W = $clog2(DEPTH + 1);
    localparam int ENT_W  = PREG_W + TAG_W;

    localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);
    localparam logic [CNTQ_W-1:0] FULL_CNT = CNTQ_W'(DEPTH);
    localparam logic [CNTQ_W-1:0] CNTQ_ONE = CNTQ_W'(1);
    localparam logic [CNT_W-1:0]  STAT_ONE = CNT_W'(1);

    typedef enum logic {
        SRC_ADD = 1'b0,
        SRC_MUL = 1'b1
    } src_e;

    logic [ENT_W-1:0]  r_addMem [DEPTH];
    logic [PTR_W-1:0]  r_addHead;
    logic [PTR_W-1:0]  r_addTail;
    logic [CNTQ_W-1:0] r_addCount;

    logic [ENT_W-1:0]  r_mulMem [DEPTH];
    logic [PTR_W-1:0]  r_mulHead;
    logic [PTR_W-1:0]  r_mulTail;
    logic [CNTQ_W-1:0] r_mulCount;

    src_e              r_rrPtr;
    logic              r_validCdb;
    logic [PREG_W-1:0] r_PwCdb;
    logic [TAG_W-1:0]  r_tagCdb;
    src_e              r_srcCdb;
    logic [CNT_W-1:0]  r_cntConflict;

    logic              w_addEmpty;
    logic              w_addFull;
    logic              w_addPush;
    logic              w_addPop;
    logic              w_mulEmpty;
    logic              w_mulFull;
    logic              w_mulPush;
    logic              w_mulPop;
    logic              w_contend;
    logic              w_grantAdd;
    logic              w_grantMul;
    logic [ENT_W-1:0]  w_addHeadEnt;
    logic [ENT_W-1:0]  w_mulHeadEnt;

    function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_ONE;
    endfunction

    // Queue status comes purely from the registered counts, so ready never
    // depends on a same-cycle pop and a full queue refuses even while draining.
    assign w_addEmpty = (r_addCount == '0);
    assign w_addFull  = (r_addCount == FULL_CNT);
    assign w_mulEmpty = (r_mulCount == '0);
    assign w_mulFull  = (r_mulCount == FULL_CNT);

    assign w_addHeadEnt = r_addMem[r_addHead];
    assign w_mulHeadEnt = r_mulMem[r_mulHead];

    // Round-robin only matters when both heads are waiting; otherwise the
    // lone non-empty queue wins outright.
    assign w_contend  = !w_addEmpty && !w_mulEmpty;
    assign w_grantAdd = !w_addEmpty && (w_mulEmpty || (r_rrPtr == SRC_ADD));
    assign w_grantMul = !w_mulEmpty && (w_addEmpty || (r_rrPtr == SRC_MUL));

    // Reset and flush both suppress queue traffic, which drops offered pushes
    // and keeps a granted head from being consumed into a discarded queue.
    assign w_addPush = rst && !flush && bus.valid_Result_add && !w_addFull;
    assign w_mulPush = rst && !flush && bus.valid_Result_mul && !w_mulFull;
    assign w_addPop  = rst && !flush && w_grantAdd;
    assign w_mulPop  = rst && !flush && w_grantMul;

    // Queue storage carries no reset; only the pointers and counts define
    // which entries are live.
    always_ff @(posedge clk) begin
        if (w_addPush) begin
            r_addMem[r_addTail] <= {bus.Pw_Result_add, bus.tag_ROB_add};
        end
        if (w_mulPush) begin
            r_mulMem[r_mulTail] <= {bus.Pw_Result_mul, bus.tag_ROB_mul};
        end
    end

    // ADD queue bookkeeping: simultaneous push and pop leave the count alone.
    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            r_addHead  <= '0;
            r_addTail  <= '0;
            r_addCount <= '0;
        end else begin
            if (w_addPush) begin
                r_addTail <= nextPtr(r_addTail);
            end
            if (w_addPop) begin
                r_addHead <= nextPtr(r_addHead);
            end
            case ({w_addPush, w_addPop})
                2'b10:   r_addCount <= r_addCount + CNTQ_ONE;
                2'b01:   r_addCount <= r_addCount - CNTQ_ONE;
                default: r_addCount <= r_addCount;
            endcase
        end
    end

    // MUL queue bookkeeping mirrors the ADD side.
    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            r_mulHead  <= '0;
            r_mulTail  <= '0;
            r_mulCount <= '0;
        end else begin
            if (w_mulPush) begin
                r_mulTail <= nextPtr(r_mulTail);
            end
            if (w_mulPop) begin
                r_mulHead <= nextPtr(r_mulHead);
            end
            case ({w_mulPush, w_mulPop})
                2'b10:   r_mulCount <= r_mulCount + CNTQ_ONE;
                2'b01:   r_mulCount <= r_mulCount - CNTQ_ONE;
                default: r_mulCount <= r_mulCount;
            endcase
        end
    end

    // Arbiter state and the CDB output register. Payload fields hold their
    // last broadcast value when no grant happens; only valid drops.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rrPtr    <= SRC_ADD;
            r_validCdb <= 1'b0;
            r_PwCdb    <= '0;
            r_tagCdb   <= '0;
            r_srcCdb   <= SRC_ADD;
        end else if (flush) begin
            r_rrPtr    <= SRC_ADD;
            r_validCdb <= 1'b0;
        end else if (w_grantAdd) begin
            r_validCdb            <= 1'b1;
            {r_PwCdb, r_tagCdb}   <= w_addHeadEnt;
            r_srcCdb              <= SRC_ADD;
            if (w_contend) begin
                r_rrPtr <= SRC_MUL;
            end
        end else if (w_grantMul) begin
            r_validCdb            <= 1'b1;
            {r_PwCdb, r_tagCdb}   <= w_mulHeadEnt;
            r_srcCdb              <= SRC_MUL;
            if (w_contend) begin
                r_rrPtr <= SRC_ADD;
            end
        end else begin
            r_validCdb <= 1'b0;
        end
    end

    // Contention statistic: counts cycles that started with both queues
    // occupied, saturating, and deliberately survives a flush.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cntConflict <= '0;
        end else if (w_contend && (r_cntConflict != '1)) begin
            r_cntConflict <= r_cntConflict + STAT_ONE;
        end
    end

    assign bus.ready_add    = !w_addFull;
    assign bus.ready_mul    = !w_mulFull;
    assign bus.valid_cdb    = r_validCdb;
    assign bus.Pw_cdb       = r_PwCdb;
    assign bus.tag_ROB_cdb  = r_tagCdb;
    assign bus.src_cdb      = r_srcCdb;
    assign bus.cnt_conflict = r_cntConflict;

endmodule
